// File: rtl/fp_divider.sv
`default_nettype none
// ============================================================================
//  Module      : fp_divider
//  Description : FP32 divider (a / b). Restoring division, one quotient bit
//                per cycle, round-to-nearest-even, valid/ready handshakes.
//                Define FP_DIV_DENORM_EN for full subnormal support;
//                otherwise subnormals flush to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_divider (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out,
    output logic        div_by_zero,
    output logic        invalid
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PREP  = 3'd1,
        S_DIV   = 3'd2,
        S_ROUND = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [31:0] c_QNAN      = 32'h7FC0_0000;
    localparam logic [4:0]  c_LAST_ITER = 5'd26;

    state_t            state_q, state_d;
    logic [31:0]       a_q, a_d, b_q, b_d;
    logic              sign_q, sign_d;
    logic signed [9:0] exp_q, exp_d;
    logic [24:0]       rem_q, rem_d;
    logic [23:0]       div_q, div_d;
    logic [26:0]       quo_q, quo_d;
    logic [4:0]        cnt_q, cnt_d;
    logic [31:0]       out_q, out_d;
    logic              dbz_q, dbz_d;
    logic              inv_q, inv_d;

`ifdef FP_DIV_DENORM_EN
    function automatic logic [4:0] lzc24(input logic [23:0] v);
        logic [4:0] n;
        logic       found;
        n     = 5'd24;
        found = 1'b0;
        for (int i = 23; i >= 0; i--) begin
            if (!found && v[i]) begin
                n     = 5'(23 - i);
                found = 1'b1;
            end
        end
        return n;
    endfunction
`endif

    function automatic void unpack(
        input  logic [30:0]       x,
        output logic [23:0]       m,
        output logic signed [9:0] e,
        output logic              zero,
        output logic              inf,
        output logic              nan
    );
        logic [7:0]  ex;
        logic [22:0] fr;
`ifdef FP_DIV_DENORM_EN
        logic [4:0]  lz;
`endif
        ex   = x[30:23];
        fr   = x[22:0];
        inf  = (ex == 8'hFF) && (fr == '0);
        nan  = (ex == 8'hFF) && (fr != '0);
`ifdef FP_DIV_DENORM_EN
        // Subnormals are normalized here so DIV always sees a leading one.
        zero = (ex == 8'h00) && (fr == '0);
        m    = {(ex != 8'h00), fr};
        e    = (ex == 8'h00) ? 10'sd1 : $signed({2'b00, ex});
        lz   = lzc24(m);
        m    = m << lz;
        e    = e - $signed({5'b00000, lz});
`else
        zero = (ex == 8'h00);
        m    = {1'b1, fr};
        e    = $signed({2'b00, ex});
`endif
    endfunction

    logic [23:0]       w_ma, w_mb;
    logic signed [9:0] w_ea, w_eb;
    logic              w_a_zero, w_a_inf, w_a_nan;
    logic              w_b_zero, w_b_inf, w_b_nan;
    logic              w_sign;

    always_comb begin
        unpack(a_q[30:0], w_ma, w_ea, w_a_zero, w_a_inf, w_a_nan);
        unpack(b_q[30:0], w_mb, w_eb, w_b_zero, w_b_inf, w_b_nan);
        w_sign = a_q[31] ^ b_q[31];
    end

    logic              w_ge;
    logic [24:0]       w_rem_sub;
    assign w_ge      = (rem_q >= {1'b0, div_q});
    assign w_rem_sub = w_ge ? (rem_q - {1'b0, div_q}) : rem_q;

    logic [22:0]       w_frac;
    logic              w_g, w_s, w_inc;
    logic signed [9:0] w_e_norm, w_e_rnd;
    logic [23:0]       w_sum;
    logic [31:0]       w_rnd_out;
`ifdef FP_DIV_DENORM_EN
    logic signed [9:0] w_shf;
    logic [4:0]        w_sh;
    logic [25:0]       w_ext, w_shifted, w_lost;
    logic [23:0]       w_dsig, w_dsum;
    logic              w_dinc;
`endif

    always_comb begin
        if (quo_q[26]) begin
            w_frac   = quo_q[25:3];
            w_g      = quo_q[2];
            w_s      = (|quo_q[1:0]) | (|rem_q);
            w_e_norm = exp_q;
        end else begin
            w_frac   = quo_q[24:2];
            w_g      = quo_q[1];
            w_s      = quo_q[0] | (|rem_q);
            w_e_norm = exp_q - 10'sd1;
        end
        w_inc   = w_g & (w_s | w_frac[0]);
        w_sum   = {1'b0, w_frac} + {23'd0, w_inc};
        w_e_rnd = w_sum[23] ? (w_e_norm + 10'sd1) : w_e_norm;
`ifdef FP_DIV_DENORM_EN
        // Right-shift {1.frac, G, S} into the subnormal range, keeping a sticky.
        w_shf     = 10'sd1 - w_e_norm;
        w_sh      = (w_shf > 10'sd26) ? 5'd26 : w_shf[4:0];
        w_ext     = {1'b1, w_frac, w_g, w_s};
        w_shifted = w_ext >> w_sh;
        w_lost    = w_ext << (5'd26 - w_sh);
        w_dsig    = w_shifted[25:2];
        w_dinc    = w_shifted[1] & (w_shifted[0] | (|w_lost) | w_dsig[0]);
        w_dsum    = w_dsig + {23'd0, w_dinc};
        if (w_e_norm <= 10'sd0)
            w_rnd_out = {sign_q, 7'd0, w_dsum};
        else if (w_e_rnd >= 10'sd255)
            w_rnd_out = {sign_q, 8'hFF, 23'd0};
        else
            w_rnd_out = {sign_q, w_e_rnd[7:0], w_sum[22:0]};
`else
        if (w_e_rnd >= 10'sd255)
            w_rnd_out = {sign_q, 8'hFF, 23'd0};
        else if (w_e_rnd <= 10'sd0)
            w_rnd_out = {sign_q, 31'd0};
        else
            w_rnd_out = {sign_q, w_e_rnd[7:0], w_sum[22:0]};
`endif
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sign_d  = sign_q;
        exp_d   = exp_q;
        rem_d   = rem_q;
        div_d   = div_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        dbz_d   = dbz_q;
        inv_d   = inv_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    dbz_d   = 1'b0;
                    inv_d   = 1'b0;
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                sign_d  = w_sign;
                state_d = S_DONE;
                if (w_a_nan || w_b_nan || (w_a_zero && w_b_zero) || (w_a_inf && w_b_inf)) begin
                    out_d = c_QNAN;
                    inv_d = 1'b1;
                end else if (w_a_inf) begin
                    out_d = {w_sign, 8'hFF, 23'd0};
                end else if (w_b_zero) begin
                    out_d = {w_sign, 8'hFF, 23'd0};
                    dbz_d = 1'b1;
                end else if (w_a_zero || w_b_inf) begin
                    out_d = {w_sign, 31'd0};
                end else begin
                    rem_d   = {1'b0, w_ma};
                    div_d   = w_mb;
                    exp_d   = w_ea - w_eb + 10'sd127;
                    quo_d   = '0;
                    cnt_d   = '0;
                    state_d = S_DIV;
                end
            end
            S_DIV: begin
                quo_d = {quo_q[25:0], w_ge};
                rem_d = w_rem_sub << 1;
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == c_LAST_ITER)
                    state_d = S_ROUND;
            end
            S_ROUND: begin
                out_d   = w_rnd_out;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sign_q  <= 1'b0;
            exp_q   <= '0;
            rem_q   <= '0;
            div_q   <= '0;
            quo_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            dbz_q   <= 1'b0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sign_q  <= sign_d;
            exp_q   <= exp_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            quo_q   <= quo_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            dbz_q   <= dbz_d;
            inv_q   <= inv_d;
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_DONE);
    assign out         = out_q;
    assign div_by_zero = dbz_q;
    assign invalid     = inv_q;

endmodule
`default_nettype wire

// File: tb/tb_fp_divider.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fp_divider
//  Description : Directed self-checking bench for fp_divider with a
//                scoreboard of expected results and latencies.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_divider;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        in_valid  = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] a         = '0;
    logic [31:0] b         = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out;
    logic        div_by_zero;
    logic        invalid;

    typedef struct {
        logic [31:0] o;
        logic        d;
        logic        i;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    fp_divider dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out         (out),
        .div_by_zero (div_by_zero),
        .invalid     (invalid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb,
                          input logic [31:0] eo, input logic ed, input logic ei,
                          input int elat, input int hold, input string tag);
        exp_t e;
        exp_t got;
        int   lat;
        e.o = eo; e.d = ed; e.i = ei; e.lat = elat;
        sb.push_back(e);
        @(negedge clk);
        chk({tag, "/in_ready_idle"}, {31'd0, in_ready}, 32'd1);
        a = ta; b = tb; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        if (sb.size() == 0) begin
            fails++;
            checks++;
            $error("FAIL %s/scoreboard: observed=empty expected=entry", tag);
        end else begin
            got = sb.pop_front();
            chk({tag, "/latency"}, lat, got.lat);
            chk({tag, "/out"}, out, got.o);
            chk({tag, "/div_by_zero"}, {31'd0, div_by_zero}, {31'd0, got.d});
            chk({tag, "/invalid"}, {31'd0, invalid}, {31'd0, got.i});
            chk({tag, "/in_ready_busy"}, {31'd0, in_ready}, 32'd0);
        end
        for (int k = 0; k < hold; k++) begin
            in_valid = 1'b1;
            a = 32'h3F80_0000;
            b = 32'h4000_0000;
            @(posedge clk); #1;
            chk({tag, "/hold_valid"}, {31'd0, out_valid}, 32'd1);
            chk({tag, "/hold_out"}, out, eo);
            chk({tag, "/hold_flags"}, {30'd0, div_by_zero, invalid}, {30'd0, ed, ei});
            chk({tag, "/hold_in_ready"}, {31'd0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "/drained"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "/in_ready_after"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("reset/out", out, 32'd0);
        chk("reset/out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset/flags", {30'd0, div_by_zero, invalid}, 32'd0);
        chk("reset/in_ready", {31'd0, in_ready}, 32'd1);

        run_op(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 1'b0, 30, 0, "6div2");
        run_op(32'h3F80_0000, 32'h4040_0000, 32'h3EAA_AAAB, 1'b0, 1'b0, 30, 0, "1div3");
        run_op(32'h3F80_0000, 32'h40E0_0000, 32'h3E12_4925, 1'b0, 1'b0, 30, 0, "1div7");
        run_op(32'hC040_0000, 32'h3F80_0000, 32'hC040_0000, 1'b0, 1'b0, 30, 0, "neg3div1");
        run_op(32'h7F7F_FFFF, 32'h3F00_0000, 32'h7F80_0000, 1'b0, 1'b0, 30, 0, "overflow");
        run_op(32'hBF80_0000, 32'h0000_0000, 32'hFF80_0000, 1'b1, 1'b0, 2, 0, "divzero");
        run_op(32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b0, 1'b1, 2, 0, "zero_zero");
        run_op(32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000, 1'b0, 1'b1, 2, 0, "inf_inf");
        run_op(32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 1'b0, 1'b1, 2, 0, "nan");
        run_op(32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000, 1'b0, 1'b0, 2, 0, "inf_fin");
        run_op(32'hBF80_0000, 32'h7F80_0000, 32'h8000_0000, 1'b0, 1'b0, 2, 0, "fin_inf");
`ifdef FP_DIV_DENORM_EN
        run_op(32'h0080_0000, 32'h4000_0000, 32'h0040_0000, 1'b0, 1'b0, 30, 0, "underflow");
`else
        run_op(32'h0080_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b0, 30, 0, "underflow");
`endif
        run_op(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 1'b0, 30, 5, "backpressure");

        // Abort an operation in DIV with a one-edge reset.
        @(negedge clk);
        a = 32'h40C0_0000; b = 32'h4000_0000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midreset/out_valid", {31'd0, out_valid}, 32'd0);
        chk("midreset/in_ready", {31'd0, in_ready}, 32'd1);
        chk("midreset/out", out, 32'd0);
        repeat (40) @(posedge clk);
        #1;
        chk("midreset/no_emit", {31'd0, out_valid}, 32'd0);
        run_op(32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 1'b0, 30, 0, "after_reset");

        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
